// File: rtl/spiflash_tx_serializer.sv
// SPI flash read-data serializer: byte FIFO feeding a 1/2/4/8-lane shifter clocked by synchronized sck falls.
// Optional SPIFLASH_TX_DUMMY_EN adds a dummy_cycles port and a DUMMY state ahead of the first byte load.
module spiflash_tx_serializer #(
   parameter int DEPTH       = 4,
   parameter int MAX_LANES   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sck,
   input  logic                     cs_n,
   input  logic [1:0]               io_mode,
`ifdef SPIFLASH_TX_DUMMY_EN
   input  logic [3:0]               dummy_cycles,
`endif
   input  logic                     wr_valid,
   input  logic [7:0]               wr_data,
   output logic                     wr_ready,
   output logic [MAX_LANES-1:0]     dout,
   output logic                     dout_oe,
   output logic                     busy,
   output logic                     byte_done,
   output logic                     underrun,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [3:0]    MAX_L    = 4'(MAX_LANES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DUMMY = 2'd3;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_fall, cs_fall, cs_rise;

   logic [7:0]     mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    level_q, level_d;
   logic           push, pop, flush, load, fifo_empty;

   logic [1:0]           state_q, state_d;
   logic [7:0]           shreg_q, shreg_d, byte_v;
   logic [3:0]           rails_q, rails_d, rails_raw, rails_new;
   logic [2:0]           left_q, left_d;
   logic [MAX_LANES-1:0] dout_q, dout_d;
   logic                 oe_q, oe_d, byte_done_q, byte_done_d, underrun_q, underrun_d;
`ifdef SPIFLASH_TX_DUMMY_EN
   logic [3:0]           dcnt_q, dcnt_d;
`endif

   // Lane r of a slice takes the r-th lowest of the top 'rails' bits of the shift register.
   function automatic logic [MAX_LANES-1:0] slice_of(input logic [7:0] sh, input logic [3:0] rails);
      logic [MAX_LANES-1:0] s;
      s = '0;
      for (int r = 0; r < MAX_LANES; r++)
         if (r < int'(rails)) s[r] = sh[8 - int'(rails) + r];
      return s;
   endfunction

   function automatic logic [2:0] slices_m1(input logic [3:0] rails);
      case (rails)
         4'd1:    return 3'd7;
         4'd2:    return 3'd3;
         4'd4:    return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

   assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
   assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
   assign sck_fall   = sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];
   assign cs_fall    = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
   assign cs_rise    = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];

   assign fifo_empty = (level_q == '0);
   assign wr_ready   = (level_q != FULL_LVL);
   assign push       = wr_valid & wr_ready & ~cs_rise;

   always_comb begin
      case (io_mode)
         2'd0:    rails_raw = 4'd1;
         2'd1:    rails_raw = 4'd2;
         2'd2:    rails_raw = 4'd4;
         default: rails_raw = 4'd8;
      endcase
      rails_new = (rails_raw > MAX_L) ? MAX_L : rails_raw;
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      rails_d     = rails_q;
      left_d      = left_q;
      dout_d      = dout_q;
      oe_d        = oe_q;
      byte_done_d = 1'b0;
      underrun_d  = underrun_q;
      byte_v      = 8'hFF;
      pop         = 1'b0;
      flush       = 1'b0;
      load        = 1'b0;
`ifdef SPIFLASH_TX_DUMMY_EN
      dcnt_d      = dcnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
`ifdef SPIFLASH_TX_DUMMY_EN
               dcnt_d  = dummy_cycles;
               state_d = (dummy_cycles != 4'd0) ? ST_DUMMY : ST_LOAD;
`else
               state_d = ST_LOAD;
`endif
            end
         end
`ifdef SPIFLASH_TX_DUMMY_EN
         ST_DUMMY: begin
            if (sck_fall) begin
               dcnt_d = dcnt_q - 4'd1;
               if (dcnt_q == 4'd1) state_d = ST_LOAD;
            end
         end
`endif
         ST_LOAD:  load = sck_fall;
         ST_SHIFT: begin
            if (sck_fall) begin
               if (left_q == 3'd0) begin
                  load = 1'b1;
               end else begin
                  dout_d      = slice_of(shreg_q, rails_q);
                  shreg_d     = shreg_q << rails_q;
                  left_d      = left_q - 3'd1;
                  byte_done_d = (left_q == 3'd1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Loading drives slice 0 in the same sck_fall that fetched the byte, so bytes chain without a gap.
      if (load) begin
         if (!fifo_empty) byte_v = mem_q[rd_ptr_q];
         pop         = ~fifo_empty;
         underrun_d  = underrun_q | fifo_empty;
         rails_d     = rails_new;
         dout_d      = slice_of(byte_v, rails_new);
         shreg_d     = byte_v << rails_new;
         left_d      = slices_m1(rails_new);
         byte_done_d = (slices_m1(rails_new) == 3'd0);
         oe_d        = 1'b1;
         state_d     = ST_SHIFT;
      end

      if (cs_rise) begin
         state_d     = ST_IDLE;
         oe_d        = 1'b0;
         dout_d      = '0;
         byte_done_d = 1'b0;
         underrun_d  = 1'b0;
         flush       = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q  <= '0;
         sck_prev_q  <= 1'b0;
         cs_sync_q   <= '1;
         cs_prev_q   <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         rails_q     <= 4'd1;
         left_q      <= '0;
         dout_q      <= '0;
         oe_q        <= 1'b0;
         byte_done_q <= 1'b0;
         underrun_q  <= 1'b0;
`ifdef SPIFLASH_TX_DUMMY_EN
         dcnt_q      <= '0;
`endif
      end else begin
         sck_sync_q  <= sck_sync_d;
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
         cs_sync_q   <= cs_sync_d;
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         rails_q     <= rails_d;
         left_q      <= left_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         byte_done_q <= byte_done_d;
         underrun_q  <= underrun_d;
`ifdef SPIFLASH_TX_DUMMY_EN
         dcnt_q      <= dcnt_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_oe    = oe_q;
   assign busy       = (state_q != ST_IDLE);
   assign byte_done  = byte_done_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_spiflash_tx_serializer.sv
// Directed bench for spiflash_tx_serializer (DEPTH=4, MAX_LANES=4); set SPIFLASH_TX_DUMMY_EN to add the dummy test.
module tb_spiflash_tx_serializer;
   logic       clk = 1'b0;
   logic       rst, sck, cs_n, wr_valid;
   logic [1:0] io_mode;
   logic [7:0] wr_data;
   logic       wr_ready, dout_oe, busy, byte_done, underrun;
   logic [3:0] dout;
   logic [2:0] fifo_level;
`ifdef SPIFLASH_TX_DUMMY_EN
   logic [3:0] dummy_cycles;
`endif
   int total = 0;
   int bad = 0;
   int bd_total = 0;

   spiflash_tx_serializer #(.DEPTH(4), .MAX_LANES(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .io_mode(io_mode),
`ifdef SPIFLASH_TX_DUMMY_EN
      .dummy_cycles(dummy_cycles),
`endif
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .dout(dout), .dout_oe(dout_oe), .busy(busy), .byte_done(byte_done),
      .underrun(underrun), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (byte_done === 1'b1) bd_total++;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic push_byte(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic sck_pulse();
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; sck = 1'b0; cs_n = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; io_mode = 2'd0;
`ifdef SPIFLASH_TX_DUMMY_EN
      dummy_cycles = 4'd0;
`endif
      repeat (3) @(negedge clk);
      total++;
      if ({dout, dout_oe, wr_ready, busy, byte_done, underrun, fifo_level} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         bad++;
         $display("FAIL reset_outputs got dout=%h oe=%b rdy=%b busy=%b bd=%b ur=%b lvl=%0d exp 0 0 1 0 0 0 0",
                  dout, dout_oe, wr_ready, busy, byte_done, underrun, fifo_level);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] b;
      logic [3:0] exp;
      int bd0;
      b = 8'hA5;
      io_mode = 2'd0;
      push_byte(b);
      total++;
      if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
      cs_low();
      total++;
      if (busy !== 1'b1 || dout_oe !== 1'b0) begin bad++; $display("FAIL single_load got busy=%b oe=%b exp busy=1 oe=0", busy, dout_oe); end
      bd0 = bd_total;
      for (int i = 0; i < 8; i++) begin
         sck_pulse();
         exp = {3'b000, b[7-i]};
         total++;
         if (dout !== exp || dout_oe !== 1'b1) begin bad++; $display("FAIL single_slice%0d got dout=%h oe=%b exp dout=%h oe=1", i, dout, dout_oe, exp); end
      end
      total++;
      if (bd_total - bd0 !== 1) begin bad++; $display("FAIL single_byte_done got=%0d exp=1", bd_total - bd0); end
      total++;
      if (underrun !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL single_end got ur=%b lvl=%0d exp ur=0 lvl=0", underrun, fifo_level); end
      cs_high();
      total++;
      if (busy !== 1'b0 || dout_oe !== 1'b0 || dout !== 4'h0) begin bad++; $display("FAIL single_release got busy=%b oe=%b dout=%h exp 0 0 0", busy, dout_oe, dout); end
   endtask

   task automatic test_quad();
      logic [15:0] seq;
      logic [3:0]  exp;
      int bd0;
      seq = 16'h3CF0;
      io_mode = 2'd2;
      push_byte(8'h3C);
      push_byte(8'hF0);
      total++;
      if (fifo_level !== 3'd2) begin bad++; $display("FAIL quad_level_start got=%0d exp=2", fifo_level); end
      cs_low();
      bd0 = bd_total;
      for (int i = 0; i < 4; i++) begin
         sck_pulse();
         exp = seq[15-4*i -: 4];
         total++;
         if (dout !== exp) begin bad++; $display("FAIL quad_slice%0d got=%h exp=%h", i, dout, exp); end
         if (i == 0) begin
            total++;
            if (fifo_level !== 3'd1) begin bad++; $display("FAIL quad_level_mid got=%0d exp=1", fifo_level); end
         end
      end
      total++;
      if (bd_total - bd0 !== 2 || fifo_level !== 3'd0) begin bad++; $display("FAIL quad_end got bd=%0d lvl=%0d exp bd=2 lvl=0", bd_total - bd0, fifo_level); end
      cs_high();
   endtask

   task automatic test_octal_clip();
      logic [7:0] seq;
      logic [3:0] exp;
      int bd0;
      seq = 8'h81;
      io_mode = 2'd3;
      push_byte(seq);
      cs_low();
      bd0 = bd_total;
      for (int i = 0; i < 2; i++) begin
         sck_pulse();
         exp = seq[7-4*i -: 4];
         total++;
         if (dout !== exp) begin bad++; $display("FAIL octal_clip_slice%0d got=%h exp=%h", i, dout, exp); end
      end
      total++;
      if (bd_total - bd0 !== 1) begin bad++; $display("FAIL octal_clip_byte_done got=%0d exp=1", bd_total - bd0); end
      cs_high();
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_seq [10];
      int bd0;
      exp_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
      io_mode = 2'd0;
      push_byte(8'hF0);
      push_byte(8'h0F);
      cs_low();
      bd0 = bd_total;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) io_mode = 2'd2;
         sck_pulse();
         total++;
         if (dout !== exp_seq[i]) begin bad++; $display("FAIL b2b_slice%0d got=%h exp=%h", i, dout, exp_seq[i]); end
      end
      total++;
      if (bd_total - bd0 !== 2) begin bad++; $display("FAIL b2b_byte_done got=%0d exp=2", bd_total - bd0); end
      cs_high();
   endtask

   task automatic test_underrun();
      int bd0;
      io_mode = 2'd0;
      cs_low();
      bd0 = bd_total;
      for (int i = 0; i < 8; i++) begin
         sck_pulse();
         total++;
         if (dout !== 4'h1 || underrun !== 1'b1) begin bad++; $display("FAIL underrun_slice%0d got dout=%h ur=%b exp dout=1 ur=1", i, dout, underrun); end
      end
      total++;
      if (bd_total - bd0 !== 1) begin bad++; $display("FAIL underrun_byte_done got=%0d exp=1", bd_total - bd0); end
      cs_high();
      total++;
      if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
   endtask

   task automatic test_full_abort();
      int bd0;
      io_mode = 2'd0;
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      total++;
      if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin bad++; $display("FAIL full got rdy=%b lvl=%0d exp rdy=0 lvl=4", wr_ready, fifo_level); end
      push_byte(8'h55);
      total++;
      if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_overpush got lvl=%0d exp=4", fifo_level); end
      cs_low();
      bd0 = bd_total;
      for (int i = 0; i < 3; i++) begin
         sck_pulse();
         total++;
         if (dout !== 4'h0 || dout_oe !== 1'b1) begin bad++; $display("FAIL abort_slice%0d got dout=%h oe=%b exp dout=0 oe=1", i, dout, dout_oe); end
      end
      total++;
      if (fifo_level !== 3'd3) begin bad++; $display("FAIL abort_level_mid got=%0d exp=3", fifo_level); end
      cs_high();
      total++;
      if (fifo_level !== 3'd0 || dout_oe !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL abort_flush got lvl=%0d oe=%b rdy=%b busy=%b exp 0 0 1 0", fifo_level, dout_oe, wr_ready, busy); end
      total++;
      if (bd_total - bd0 !== 0) begin bad++; $display("FAIL abort_byte_done got=%0d exp=0", bd_total - bd0); end
   endtask

   task automatic test_push_flush();
      push_byte(8'h77);
      cs_low();
      cs_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wr_data  = 8'h99;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      total++;
      if (fifo_level !== 3'd0) begin bad++; $display("FAIL push_flush got lvl=%0d exp=0", fifo_level); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_reset();
      io_mode = 2'd0;
      push_byte(8'hC0);
      push_byte(8'hC0);
      cs_low();
      sck_pulse();
      sck_pulse();
      total++;
      if (dout !== 4'h1 || dout_oe !== 1'b1) begin bad++; $display("FAIL areset_pre got dout=%h oe=%b exp 1 1", dout, dout_oe); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({dout, dout_oe, busy, fifo_level, wr_ready} !== {4'h0, 1'b0, 1'b0, 3'd0, 1'b1})
         begin bad++; $display("FAIL areset_now got dout=%h oe=%b busy=%b lvl=%0d rdy=%b exp 0 0 0 0 1", dout, dout_oe, busy, fifo_level, wr_ready); end
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

`ifdef SPIFLASH_TX_DUMMY_EN
   task automatic test_dummy();
      io_mode = 2'd0;
      dummy_cycles = 4'd2;
      push_byte(8'h80);
      cs_low();
      for (int i = 0; i < 10; i++) begin
         sck_pulse();
         total++;
         if (i < 2) begin
            if (dout_oe !== 1'b0) begin bad++; $display("FAIL dummy_oe%0d got=%b exp=0", i, dout_oe); end
         end else if (dout !== ((i == 2) ? 4'h1 : 4'h0) || dout_oe !== 1'b1) begin
            bad++; $display("FAIL dummy_slice%0d got dout=%h oe=%b exp dout=%h oe=1", i, dout, dout_oe, (i == 2) ? 4'h1 : 4'h0);
         end
      end
      cs_high();
      dummy_cycles = 4'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_quad();
      test_octal_clip();
      test_back_to_back();
      test_underrun();
      test_full_abort();
      test_push_flush();
      test_async_reset();
`ifdef SPIFLASH_TX_DUMMY_EN
      test_dummy();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spiflash_tx_serializer.md
Name: spiflash_tx_serializer

Overview:
- Synthesizable read-data responder for the SPI flash model path.
- Buffers bytes from a producer in a small FIFO, then shifts them out on 1/2/4/8 data lanes, updating on each falling edge of the external sck.
- Runs entirely on the system clock; sck and cs_n are synchronized and edge-detected internally.
- Replaces fixed single-byte, fixed-mode return logic with parametrised lane count, buffering, underrun reporting and per-byte mode selection.

Parameters:
DEPTH, 4, FIFO depth in bytes (power of two, >=2)
MAX_LANES, 4, physical data lanes (1, 2, 4 or 8); modes wider than this clip to MAX_LANES
SYNC_STAGES, 2, synchronizer flops on sck and cs_n (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sck  input  1  SPI serial clock (asynchronous to clk)
cs_n  input  1  SPI chip select, active-low (asynchronous to clk)
io_mode  input  2  0=single, 1=dual, 2=quad, 3=octal; sampled at each byte load
wr_valid  input  1  producer byte valid
wr_data  input  8  producer byte
wr_ready  output  1  FIFO not full
dout  output  MAX_LANES  data lanes; lane r carries bit (7-k*rails-(rails-1-r)) of the current slice k
dout_oe  output  1  lane output enable
busy  output  1  cs_n asserted and shifter active
byte_done  output  1  one-clk pulse when the last slice of a byte has been driven
underrun  output  1  sticky; set when a byte is needed and the FIFO is empty
fifo_level  output  $clog2(DEPTH)+1  bytes currently buffered

Behaviour:
- Reset values: dout=0, dout_oe=0, wr_ready=1, busy=0, byte_done=0, underrun=0, fifo_level=0, FSM=IDLE, FIFO empty.
- Synchronization:
  - sck and cs_n each pass through SYNC_STAGES flops.
  - sck_fall = synchronized falling edge, asserted for one clk.
  - cs_fall and cs_rise are detected the same way.
- Clock ratio: clk must be >= 4x sck; behaviour at lower ratios is undefined.
- Lane count: rails = min(1<<io_mode, MAX_LANES); slices per byte = 8/rails.
- FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = (fifo_level != DEPTH), evaluated before that cycle's pop; a slot freed by a pop is not reusable in the same cycle.
  - Simultaneous push and pop leaves fifo_level unchanged.
- FSM:
  - IDLE: dout_oe=0. On cs_fall, go to LOAD.
  - LOAD: waits for sck_fall.
    - FIFO non-empty: pop into the shift register, latch rails, drive slice 0, dout_oe=1, go to SHIFT.
    - FIFO empty: set underrun, shift in 8'hFF, proceed identically.
  - SHIFT: each sck_fall drives the next slice.
    - After the last slice is driven, pulse byte_done.
    - The next sck_fall re-enters the LOAD behaviour in the same cycle, so back-to-back bytes have no gap edge.
  - Any state, on cs_rise:
    - Go to IDLE, dout_oe=0, dout=0.
    - Flush the FIFO (fifo_level=0) and clear underrun.
    - A partially shifted byte is discarded; no byte_done pulse.
- dout changes exactly one clk after the cycle in which sck_fall is high.
- io_mode changes mid-byte take effect only at the next byte load.
- busy = (FSM != IDLE).
- A push and a cs_rise flush in the same cycle: the flush wins and the pushed byte is dropped.
- Async rst mid-transfer immediately forces all reset values.

Optional Feature:
- Macro: SPIFLASH_TX_DUMMY_EN.
- When defined:
  - Adds input port dummy_cycles (4 bits), sampled on cs_fall.
  - FSM adds a DUMMY state between IDLE and LOAD that counts dummy_cycles sck_fall edges with dout_oe=0.
  - dummy_cycles=0 skips DUMMY.
  - cs_rise during DUMMY returns to IDLE.
- When undefined: no port, and cs_fall goes directly to LOAD.

Test Plan:
- Single mode: push 8'hA5, assert cs_n low, apply 8 sck falls -> dout[0] sequence 1,0,1,0,0,1,0,1; byte_done pulses once after the 8th; underrun=0.
- Quad mode (io_mode=2): push 8'h3C, 8'hF0, then 4 sck falls -> dout nibbles 4'h3, 4'hC, 4'hF, 4'h0; two byte_done pulses; fifo_level 2->0.
- Octal request with MAX_LANES=4: io_mode=3, byte 8'h81 -> clipped to quad, dout 4'h8 then 4'h1.
- Underrun: empty FIFO, cs_n low, 8 sck falls in single mode -> dout[0]=1 for all 8; underrun=1 until cs_n high, then 0.
- Full and abort: push DEPTH=4 bytes -> wr_ready=0, fifo_level=4. Raise cs_n mid-byte after 3 slices -> fifo_level=0, dout_oe=0, no byte_done pulse.
- SPIFLASH_TX_DUMMY_EN with dummy_cycles=2, single mode, byte 8'h80 -> dout_oe=0 for first 2 sck falls, then dout[0]=1 on the 3rd fall and 0 for the next 7.
